// File: rtl/cv32e41s_alert_handler.sv
// Alert receiver/escalation unit: leaky-bucket minor counter, NMI escalation, sticky reset request.
// Optional leak (minor_cnt decrement) is enabled by defining ALERT_HANDLER_LEAK_EN.
module cv32e41s_alert_handler #(
  parameter int unsigned MINOR_THRESHOLD = 4,
  parameter int unsigned LEAK_PERIOD     = 1024,
  parameter int unsigned NMI_TIMEOUT     = 256,
  parameter int unsigned CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alert_minor_i,
  input  logic             alert_major_i,
  input  logic             nmi_ack_i,
  input  logic             clr_i,
  output logic             nmi_req_o,
  output logic             reset_req_o,
  output logic [CNT_W-1:0] minor_cnt_o,
  output logic             major_seen_o,
  output logic [1:0]       state_o
);

  localparam int unsigned TMO_W = (NMI_TIMEOUT > 1) ? $clog2(NMI_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ESC_NMI   = 2'd1,
    ACKED     = 2'd2,
    ESC_RESET = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] minor_cnt_q, minor_cnt_d, minor_cnt_upd;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             major_seen_q, major_seen_d;
  logic             esc_minor;
  logic             clr_ok;

`ifdef ALERT_HANDLER_LEAK_EN
  localparam int unsigned LEAK_W = $clog2(LEAK_PERIOD);
  logic [LEAK_W-1:0] leak_cnt_q, leak_cnt_d, leak_cnt_upd;
`endif

  // Counter update before any clear; a minor alert beats a same-cycle leak wrap.
  always_comb begin
    minor_cnt_upd = minor_cnt_q;
`ifdef ALERT_HANDLER_LEAK_EN
    leak_cnt_upd  = leak_cnt_q;
`endif
    if (state_q != ESC_RESET) begin
      if (alert_minor_i) begin
        if (minor_cnt_q != '1) minor_cnt_upd = minor_cnt_q + 1'b1;
`ifdef ALERT_HANDLER_LEAK_EN
        leak_cnt_upd = '0;
      end else if (minor_cnt_q != '0) begin
        if (leak_cnt_q == LEAK_W'(LEAK_PERIOD - 1)) begin
          leak_cnt_upd  = '0;
          minor_cnt_upd = minor_cnt_q - 1'b1;
        end else begin
          leak_cnt_upd = leak_cnt_q + 1'b1;
        end
      end else begin
        leak_cnt_upd = '0;
`endif
      end
    end
  end

  assign esc_minor = (minor_cnt_upd >= CNT_W'(MINOR_THRESHOLD));

  always_comb begin
    state_d     = state_q;
    minor_cnt_d = minor_cnt_upd;
`ifdef ALERT_HANDLER_LEAK_EN
    leak_cnt_d  = leak_cnt_upd;
`endif
    tmo_cnt_d   = '0;
    clr_ok      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (alert_major_i || esc_minor) begin
          state_d = ESC_NMI;
        end else if (clr_i) begin
          clr_ok = 1'b1;
        end
      end
      ESC_NMI: begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (alert_major_i) begin
          state_d = ESC_RESET;
        end else if (nmi_ack_i) begin
          state_d = ACKED;
        end else if (tmo_cnt_q == TMO_W'(NMI_TIMEOUT - 1)) begin
          state_d = ESC_RESET;
        end
      end
      ACKED: begin
        if (alert_major_i) begin
          state_d = ESC_RESET;
        end else if (clr_i) begin
          state_d = IDLE;
          clr_ok  = 1'b1;
        end
      end
      ESC_RESET: state_d = ESC_RESET;
      default:   state_d = IDLE;
    endcase
    if (clr_ok) begin
      minor_cnt_d = '0;
`ifdef ALERT_HANDLER_LEAK_EN
      leak_cnt_d  = '0;
`endif
    end
  end

  always_comb begin
    major_seen_d = major_seen_q;
    if (alert_major_i)  major_seen_d = 1'b1;
    else if (clr_ok)    major_seen_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      minor_cnt_q  <= '0;
      tmo_cnt_q    <= '0;
      major_seen_q <= 1'b0;
`ifdef ALERT_HANDLER_LEAK_EN
      leak_cnt_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      minor_cnt_q  <= minor_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      major_seen_q <= major_seen_d;
`ifdef ALERT_HANDLER_LEAK_EN
      leak_cnt_q   <= leak_cnt_d;
`endif
    end
  end

  assign nmi_req_o    = (state_q == ESC_NMI);
  assign reset_req_o  = (state_q == ESC_RESET);
  assign minor_cnt_o  = minor_cnt_q;
  assign major_seen_o = major_seen_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_cv32e41s_alert_handler.sv
// Directed bench for cv32e41s_alert_handler: default instance plus a small saturating instance.
module tb_cv32e41s_alert_handler;

`ifdef ALERT_HANDLER_LEAK_EN
  localparam int unsigned LEAK = 1;
`else
  localparam int unsigned LEAK = 0;
`endif

  logic       clk = 1'b0;
  logic       rst, minor, major, ack, clr;
  logic       nmi, rreq, mseen;
  logic [7:0] mcnt;
  logic [1:0] st;

  logic       s_rst, s_minor, s_major, s_ack, s_clr;
  logic       s_nmi, s_rreq, s_mseen;
  logic [2:0] s_mcnt;
  logic [1:0] s_st;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  cv32e41s_alert_handler dut (
    .clk(clk), .rst(rst), .alert_minor_i(minor), .alert_major_i(major),
    .nmi_ack_i(ack), .clr_i(clr), .nmi_req_o(nmi), .reset_req_o(rreq),
    .minor_cnt_o(mcnt), .major_seen_o(mseen), .state_o(st)
  );

  cv32e41s_alert_handler #(.MINOR_THRESHOLD(7), .CNT_W(3)) dut_s (
    .clk(clk), .rst(s_rst), .alert_minor_i(s_minor), .alert_major_i(s_major),
    .nmi_ack_i(s_ack), .clr_i(s_clr), .nmi_req_o(s_nmi), .reset_req_o(s_rreq),
    .minor_cnt_o(s_mcnt), .major_seen_o(s_mseen), .state_o(s_st)
  );

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs set before cyc() are sampled at its posedge; outputs are read 1ns later.
  task automatic cyc(input int unsigned n = 1);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_rst();
    rst = 1'b1; cyc(); rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; minor = 0; major = 0; ack = 0; clr = 0;
    s_rst = 1'b1; s_minor = 0; s_major = 0; s_ack = 0; s_clr = 0;

    // Reset values
    cyc(2);
    rst = 1'b0; s_rst = 1'b0;
    chk("rst_state", st, 0);
    chk("rst_nmi", nmi, 0);
    chk("rst_rreq", rreq, 0);
    chk("rst_mcnt", mcnt, 0);
    chk("rst_mseen", mseen, 0);

    // Minor threshold
    for (int unsigned i = 0; i < 4; i++) begin
      minor = 1; cyc(); minor = 0;
      if (i == 2) begin
        chk("thr_below_cnt", mcnt, 3);
        chk("thr_below_state", st, 0);
      end
      if (i < 3) cyc(9);
    end
    chk("thr_cnt", mcnt, 4);
    chk("thr_state", st, 1);
    chk("thr_nmi", nmi, 1);
    ack = 1; cyc(); ack = 0;
    chk("ack_state", st, 2);
    chk("ack_nmi", nmi, 0);
    minor = 1; cyc(); minor = 0;
    chk("acked_cnt", mcnt, 5);
    chk("acked_noesc", st, 2);
    clr = 1; cyc(); clr = 0;
    chk("clr_state", st, 0);
    chk("clr_cnt", mcnt, 0);
    ack = 1; cyc(); ack = 0;
    chk("idle_ack_ignored", st, 0);

    // Major alert and NMI timeout
    major = 1; cyc(); major = 0;
    chk("maj_nmi", nmi, 1);
    chk("maj_seen", mseen, 1);
    cyc(255);
    chk("tmo_not_yet", rreq, 0);
    chk("tmo_not_yet_st", st, 1);
    cyc();
    chk("tmo_rreq", rreq, 1);
    chk("tmo_state", st, 3);
    chk("tmo_nmi", nmi, 0);
    clr = 1; ack = 1; minor = 1; cyc(); clr = 0; ack = 0; minor = 0;
    chk("sticky_rreq", rreq, 1);
    chk("sticky_frozen_cnt", mcnt, 0);
    chk("sticky_mseen", mseen, 1);
    do_rst();
    chk("rst2_rreq", rreq, 0);
    chk("rst2_mseen", mseen, 0);
    chk("rst2_state", st, 0);

    // Leak
    minor = 1; cyc(); minor = 0;
    chk("leak_start", mcnt, 1);
    cyc(1023);
    chk("leak_hold", mcnt, 1);
    cyc();
    chk("leak_drop", mcnt, (LEAK != 0) ? 0 : 1);
    minor = 1; cyc(); minor = 0;
    cyc(1023);
    minor = 1; cyc(); minor = 0;
    chk("leak_wrap_minor", mcnt, (LEAK != 0) ? 2 : 3);
    chk("leak_wrap_state", st, 0);
    do_rst();

    // Priority in ACKED and ESC_NMI
    major = 1; cyc(); major = 0;
    ack = 1; cyc(); ack = 0;
    chk("pri_acked", st, 2);
    major = 1; clr = 1; cyc(); major = 0; clr = 0;
    chk("pri_acked_state", st, 3);
    chk("pri_acked_rreq", rreq, 1);
    chk("pri_acked_mseen", mseen, 1);
    do_rst();
    major = 1; cyc(); major = 0;
    ack = 1; major = 1; cyc(); ack = 0; major = 0;
    chk("pri_nmi_state", st, 3);
    do_rst();

    // Saturation on the small instance
    s_minor = 1;
    cyc(6);
    chk("sat_6_cnt", s_mcnt, 6);
    chk("sat_6_state", s_st, 0);
    cyc();
    chk("sat_7_state", s_st, 1);
    cyc(5);
    s_minor = 0;
    chk("sat_cnt", s_mcnt, 7);
    chk("sat_state", s_st, 1);
    chk("sat_nmi", s_nmi, 1);
    s_rst = 1; cyc(); s_rst = 0;
    chk("sat_rst_cnt", s_mcnt, 0);
    chk("sat_rst_state", s_st, 0);
    chk("sat_rst_nmi", s_nmi, 0);
    chk("sat_rst_rreq", s_rreq, 0);
    chk("sat_rst_mseen", s_mseen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
